// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the seven-segment scan driver.
// Segment encoding is active-low, bit order SEG[0]=a ... SEG[6]=g.
// Holds the off patterns, segment bit indices and one glyph per supported character.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    // Digits
    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = ~((7'd1 << SEG_B) | (7'd1 << SEG_C));
    localparam logic [6:0] GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000;
    localparam logic [6:0] GLYPH_4 = 7'b0011001;
    localparam logic [6:0] GLYPH_5 = 7'b0010010;
    localparam logic [6:0] GLYPH_6 = 7'b0000010;
    localparam logic [6:0] GLYPH_7 = 7'b1111000;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0010000;

    // Letters; upper and lower case share one glyph
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b0000011;
    localparam logic [6:0] GLYPH_C = 7'b1000110;
    localparam logic [6:0] GLYPH_D = 7'b0100001;
    localparam logic [6:0] GLYPH_E = 7'b0000110;
    localparam logic [6:0] GLYPH_F = 7'b0001110;
    localparam logic [6:0] GLYPH_G = 7'b1000010;
    localparam logic [6:0] GLYPH_H = 7'b0001001;
    localparam logic [6:0] GLYPH_I = ~((7'd1 << SEG_E) | (7'd1 << SEG_F));
    localparam logic [6:0] GLYPH_J = 7'b1100001;
    localparam logic [6:0] GLYPH_K = 7'b0001010;
    localparam logic [6:0] GLYPH_L = 7'b1000111;
    localparam logic [6:0] GLYPH_M = 7'b1101010;
    localparam logic [6:0] GLYPH_N = 7'b0101011;
    localparam logic [6:0] GLYPH_O = 7'b0100011;
    localparam logic [6:0] GLYPH_P = 7'b0001100;
    localparam logic [6:0] GLYPH_Q = 7'b0011000;
    localparam logic [6:0] GLYPH_R = 7'b0101111;
    localparam logic [6:0] GLYPH_S = 7'b0010010;
    localparam logic [6:0] GLYPH_T = 7'b0000111;
    localparam logic [6:0] GLYPH_U = 7'b1000001;
    localparam logic [6:0] GLYPH_V = 7'b1100011;
    localparam logic [6:0] GLYPH_W = 7'b1010101;
    localparam logic [6:0] GLYPH_X = 7'b1001001;
    localparam logic [6:0] GLYPH_Y = 7'b0010001;
    localparam logic [6:0] GLYPH_Z = 7'b0100100;

    // Punctuation and the fallback for anything unsupported
    localparam logic [6:0] GLYPH_BLANK   = SEG_OFF;
    localparam logic [6:0] GLYPH_DASH    = ~(7'd1 << SEG_G);
    localparam logic [6:0] GLYPH_UNDER   = ~(7'd1 << SEG_D);
    localparam logic [6:0] GLYPH_UNKNOWN = ~((7'd1 << SEG_A) | (7'd1 << SEG_D) | (7'd1 << SEG_G));

endpackage

// File: rtl/seg7_font.sv
// seg7_font: combinational ASCII to active-low seven-segment lookup.
// Ports: ascii[7:0] character code in; seg_c[6:0] active-low segments out (a = bit 0).
module seg7_font
    import seg7_pkg::*;
(
    input  logic [7:0] ascii,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = GLYPH_UNKNOWN;
        case (ascii)
            8'h20:        seg_c = GLYPH_BLANK;
            8'h2D:        seg_c = GLYPH_DASH;
            8'h5F:        seg_c = GLYPH_UNDER;
            8'h30:        seg_c = GLYPH_0;
            8'h31:        seg_c = GLYPH_1;
            8'h32:        seg_c = GLYPH_2;
            8'h33:        seg_c = GLYPH_3;
            8'h34:        seg_c = GLYPH_4;
            8'h35:        seg_c = GLYPH_5;
            8'h36:        seg_c = GLYPH_6;
            8'h37:        seg_c = GLYPH_7;
            8'h38:        seg_c = GLYPH_8;
            8'h39:        seg_c = GLYPH_9;
            8'h41, 8'h61: seg_c = GLYPH_A;
            8'h42, 8'h62: seg_c = GLYPH_B;
            8'h43, 8'h63: seg_c = GLYPH_C;
            8'h44, 8'h64: seg_c = GLYPH_D;
            8'h45, 8'h65: seg_c = GLYPH_E;
            8'h46, 8'h66: seg_c = GLYPH_F;
            8'h47, 8'h67: seg_c = GLYPH_G;
            8'h48, 8'h68: seg_c = GLYPH_H;
            8'h49, 8'h69: seg_c = GLYPH_I;
            8'h4A, 8'h6A: seg_c = GLYPH_J;
            8'h4B, 8'h6B: seg_c = GLYPH_K;
            8'h4C, 8'h6C: seg_c = GLYPH_L;
            8'h4D, 8'h6D: seg_c = GLYPH_M;
            8'h4E, 8'h6E: seg_c = GLYPH_N;
            8'h4F, 8'h6F: seg_c = GLYPH_O;
            8'h50, 8'h70: seg_c = GLYPH_P;
            8'h51, 8'h71: seg_c = GLYPH_Q;
            8'h52, 8'h72: seg_c = GLYPH_R;
            8'h53, 8'h73: seg_c = GLYPH_S;
            8'h54, 8'h74: seg_c = GLYPH_T;
            8'h55, 8'h75: seg_c = GLYPH_U;
            8'h56, 8'h76: seg_c = GLYPH_V;
            8'h57, 8'h77: seg_c = GLYPH_W;
            8'h58, 8'h78: seg_c = GLYPH_X;
            8'h59, 8'h79: seg_c = GLYPH_Y;
            8'h5A, 8'h7A: seg_c = GLYPH_Z;
            default:      seg_c = GLYPH_UNKNOWN;
        endcase
    end

endmodule

// File: rtl/seg7_ascii_scan.sv
// seg7_ascii_scan: four-digit ASCII seven-segment scan driver.
// Snapshots WORD/DP_IN at each frame boundary and multiplexes digits 3..0 onto
// active-low pins, REFRESH_DIV cycles per digit, with all pins registered.
// Optional build macro SEG7_BLANK_EN: anodes off for the first BLANK_CYCLES of each slot.
// Ports: CLK clock; RESETN sync active-low reset; WORD four ASCII chars (31:24 leftmost);
//        DP_IN per-digit decimal point request; SEG/AN/DP active-low pins;
//        FRAME_START one-cycle pulse when a new snapshot is taken.
module seg7_ascii_scan
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic [31:0] WORD,
    input  logic [3:0]  DP_IN,
    output logic [6:0]  SEG,
    output logic [3:0]  AN,
    output logic        DP,
    output logic        FRAME_START
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

    if (REFRESH_DIV < 2 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_param
        $error("seg7_ascii_scan: need REFRESH_DIV >= 2 and BLANK_CYCLES < REFRESH_DIV");
    end

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [31:0]      sw;
    logic [3:0]       sdp;

    logic       slot_end_c;
    logic       frame_end_c;
    logic       blank_c;
    logic [7:0] cur_char_c;
    logic [6:0] cur_glyph_c;
    logic [3:0] an_c;
    logic       dp_c;

    // Slot/frame boundaries and the digit currently selected
    always_comb begin
        slot_end_c  = (cnt == CNT_W'(REFRESH_DIV - 1));
        frame_end_c = slot_end_c && (idx == 2'd0);
        cur_char_c  = sw[{idx, 3'b000} +: 8];
        an_c        = ~(4'b0001 << idx);
        dp_c        = ~sdp[idx];
`ifdef SEG7_BLANK_EN
        blank_c     = (cnt < CNT_W'(BLANK_CYCLES));
`else
        blank_c     = 1'b0;
`endif
    end

    seg7_font u_font (
        .ascii (cur_char_c),
        .seg_c (cur_glyph_c)
    );

    // Prescaler, digit index and tear-free shadow of WORD/DP_IN
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            cnt         <= '0;
            idx         <= 2'd3;
            sw          <= WORD;
            sdp         <= DP_IN;
            FRAME_START <= 1'b0;
        end else begin
            cnt         <= slot_end_c ? '0 : cnt + CNT_W'(1);
            FRAME_START <= frame_end_c;
            if (slot_end_c) begin
                idx <= idx - 2'd1;
            end
            if (frame_end_c) begin
                sw  <= WORD;
                sdp <= DP_IN;
            end
        end
    end

    // Pin registers driven from the pre-edge digit selection
    always_ff @(posedge CLK) begin
        if (!RESETN || blank_c) begin
            SEG <= SEG_OFF;
            AN  <= AN_OFF;
            DP  <= 1'b1;
        end else begin
            SEG <= cur_glyph_c;
            AN  <= an_c;
            DP  <= dp_c;
        end
    end

endmodule

// File: tb/tb_seg7_ascii_scan.sv
// tb_seg7_ascii_scan: scoreboard bench for seg7_ascii_scan (REFRESH_DIV=4, BLANK_CYCLES=1).
// A timeline model predicts the pins after every clock edge and queues them;
// a monitor on the falling edge pops and compares.
module tb_seg7_ascii_scan;
    import seg7_pkg::*;

    localparam int unsigned DIV   = 4;
    localparam int unsigned BLANK = 1;
    localparam int unsigned FRAME = 4 * DIV;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] an;
        logic       dp;
        logic       fs;
        logic       rst;
    } pins_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] word;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic        fs;

    pins_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    always #5 clk = ~clk;

    seg7_ascii_scan #(
        .REFRESH_DIV  (DIV),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .CLK         (clk),
        .RESETN      (rstn),
        .WORD        (word),
        .DP_IN       (dp_in),
        .SEG         (seg),
        .AN          (an),
        .DP          (dp),
        .FRAME_START (fs)
    );

    // Reference font
    logic [6:0] digit_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                   7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [6:0] letter_tab [26] = '{GLYPH_A, GLYPH_B, GLYPH_C, GLYPH_D, GLYPH_E, GLYPH_F,
                                    GLYPH_G, GLYPH_H, GLYPH_I, GLYPH_J, GLYPH_K, GLYPH_L,
                                    GLYPH_M, GLYPH_N, GLYPH_O, GLYPH_P, GLYPH_Q, GLYPH_R,
                                    GLYPH_S, GLYPH_T, GLYPH_U, GLYPH_V, GLYPH_W, GLYPH_X,
                                    GLYPH_Y, GLYPH_Z};

    function automatic logic [6:0] font_ref(input logic [7:0] c);
        int v;
        v = int'(c);
        if (v >= 48 && v <= 57) return digit_tab[v - 48];
        if (v >= 97 && v <= 122) v = v - 32;
        if (v >= 65 && v <= 90) return letter_tab[v - 65];
        if (v == 32) return 7'h7F;
        if (v == 45) return 7'b0111111;
        if (v == 95) return 7'b1110111;
        return 7'b0110110;
    endfunction

    // Timeline model: cyc counts running edges since reset release
    int          cyc = 0;
    logic [31:0] snap_w;
    logic [3:0]  snap_dp;

    always @(posedge clk) begin : model
        pins_t e;
        int    pos;
        int    digit;
        int    phase;
        if (!rstn) begin
            e       = '{seg: 7'h7F, an: 4'hF, dp: 1'b1, fs: 1'b0, rst: 1'b1};
            snap_w  = word;
            snap_dp = dp_in;
            cyc     = 0;
        end else begin
            pos   = cyc % FRAME;
            digit = 3 - pos / DIV;
            phase = pos % DIV;
            e.an        = 4'hF;
            e.an[digit] = 1'b0;
            e.seg       = font_ref(snap_w[8*digit +: 8]);
            e.dp        = ~snap_dp[digit];
            e.fs        = (pos == FRAME - 1);
            e.rst       = 1'b0;
`ifdef SEG7_BLANK_EN
            if (phase < BLANK) begin
                e.seg = 7'h7F;
                e.an  = 4'hF;
                e.dp  = 1'b1;
            end
`endif
            if (pos == FRAME - 1) begin
                snap_w  = word;
                snap_dp = dp_in;
            end
            cyc++;
        end
        exp_q.push_back(e);
    end

    // Monitor: compares pins, anode exclusivity and FRAME_START spacing
    int    fs_gap   = 0;
    bit    fs_valid = 1'b0;
    pins_t got_e;

    always @(negedge clk) begin : monitor
        if (exp_q.size() > 0) begin
            got_e = exp_q.pop_front();
            n_tests++;
            if (seg !== got_e.seg || an !== got_e.an || dp !== got_e.dp || fs !== got_e.fs) begin
                n_fail++;
                $display("FAIL pins @%0t: got seg=%b an=%b dp=%b fs=%b, expected seg=%b an=%b dp=%b fs=%b",
                         $time, seg, an, dp, fs, got_e.seg, got_e.an, got_e.dp, got_e.fs);
            end
            n_tests++;
            if ($countones(~an) > 1) begin
                n_fail++;
                $display("FAIL anode_onehot @%0t: got an=%b, expected at most one low", $time, an);
            end
            if (got_e.rst) fs_valid = 1'b0;
            if (fs === 1'b1) begin
                if (fs_valid) begin
                    n_tests++;
                    if (fs_gap != FRAME) begin
                        n_fail++;
                        $display("FAIL frame_period @%0t: got %0d cycles, expected %0d", $time, fs_gap, FRAME);
                    end
                end
                fs_valid = 1'b1;
                fs_gap   = 0;
            end
            fs_gap++;
        end
    end

    task automatic check_lit(input string name, input logic [3:0] ea, input logic [6:0] es, input logic ed);
        n_tests++;
        if (an !== ea || seg !== es || dp !== ed) begin
            n_fail++;
            $display("FAIL %s: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                     name, an, seg, dp, ea, es, ed);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bounded wait until the model's frame position reaches target
    task automatic wait_pos(input int target);
        int i;
        for (i = 0; i < 2 * FRAME && (cyc % FRAME) != target; i++) @(negedge clk);
        if ((cyc % FRAME) != target) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_pos: got pos=%0d, expected %0d within %0d cycles", cyc % FRAME, target, 2 * FRAME);
        end
    endtask

    function automatic logic [7:0] rand_char();
        string cs;
        cs = " -_0123456789AbCdEfHLnoPrStUy#!?";
        if ($urandom_range(0, 3) == 0) return 8'($urandom_range(0, 255));
        return cs[$urandom_range(0, cs.len() - 1)];
    endfunction

    initial begin
        rstn  = 1'b0;
        word  = " 012";
        dp_in = 4'b0000;
        wait_cycles(3);
        check_lit("reset_state", 4'hF, 7'h7F, 1'b1);
        rstn = 1'b1;

        // Scan order after release, then a mid-frame WORD change at idx=1
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            case (k)
                2:  check_lit("d3_blank_char", 4'b0111, 7'h7F, 1'b1);
                6:  check_lit("d2_zero", 4'b1011, 7'b1000000, 1'b1);
                10: begin
                        check_lit("d1_one", 4'b1101, 7'b1111001, 1'b1);
                        word = "-#21";
                    end
                14: check_lit("d0_two_old_frame", 4'b1110, 7'b0100100, 1'b1);
                18: check_lit("new_d3_dash", 4'b0111, 7'b0111111, 1'b1);
                22: check_lit("new_d2_unknown", 4'b1011, 7'b0110110, 1'b1);
                26: check_lit("new_d1_two", 4'b1101, 7'b0100100, 1'b1);
                30: check_lit("new_d0_one", 4'b1110, 7'b1111001, 1'b1);
                default: ;
            endcase
        end

        // Free-running frames
        wait_cycles(3 * FRAME);

        // Decimal points, then a deferred mid-frame change
        dp_in = 4'b0101;
        wait_cycles(40);
        wait_pos(6);
        dp_in = 4'b1010;
        wait_cycles(2 * FRAME);

        // One-cycle reset during the idx=1 slot
        word = "rAm_";
        wait_pos(9);
        rstn = 1'b0;
        @(negedge clk);
        check_lit("reset_pulse_off", 4'hF, 7'h7F, 1'b1);
        rstn = 1'b1;
        wait_cycles(2);
        check_lit("restart_d3", 4'b0111, font_ref(word[31:24]), ~dp_in[3]);
        wait_cycles(40);

        // Randomized words, decimal points and occasional resets
        for (int it = 0; it < 60; it++) begin
            word  = {rand_char(), rand_char(), rand_char(), rand_char()};
            dp_in = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) begin
                rstn = 1'b0;
                wait_cycles(int'($urandom_range(1, 3)));
                rstn = 1'b1;
            end
            wait_cycles(int'($urandom_range(1, 40)));
        end

        wait_cycles(3);
        n_tests++;
        if (exp_q.size() > 1) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected at most 1", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
